disp_frame_ctrl: RTL and testbench
==================================

Name: disp_frame_ctrl

Overview:
- Frame controller for the 8-digit multiplexed 7-segment display driver.
- Generates the digit-advance strobe DISP_CE and tracks the driver's digit counter.
- Arbitrates two requesters that want to write display content (32-bit hex, decimal points, blanking mask).
- Applies a new image only at a frame boundary, so a digit is never shown with mixed old/new data.

Parameters:
- CE_DIV, 12500: CLK cycles per digit, ≥2; 100 MHz / 12500 = 8 kHz digit rate.
- BLINK_FRAMES, 64: frames per blink half-period, ≥1; used only with DISP_BLINK_EN.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- REQ0  in  1  requester 0 write request (level)
- HEX0  in  32  requester 0 hex nibbles, digit 0 = [3:0]
- DP0  in  8  requester 0 decimal points, 1 = lit
- OFF0  in  8  requester 0 digit blanking, 1 = blank
- REQ1/HEX1/DP1/OFF1  in  1/32/8/8  requester 1, same meaning as requester 0
- GNT0  out  1  one-cycle pulse: requester 0 data accepted
- GNT1  out  1  one-cycle pulse: requester 1 data accepted
- DISP_CE  out  1  digit-advance strobe to the display driver
- HEX_OUT  out  32  image hex to the driver
- DP_OUT  out  8  image decimal points to the driver
- OFF_OUT  out  8  image blanking to the driver
- FRAME_SOF  out  1  one-cycle pulse after each frame boundary
- BLINK_MASK  in  8  digits to blink; present only with DISP_BLINK_EN

Behaviour:
- Reset values (async, while RST=1):
  - Prescaler count PCNT=0, phase counter PH=7.
  - DISP_CE=0, GNT0=GNT1=0, FRAME_SOF=0.
  - HEX_OUT=0, DP_OUT=0, OFF_OUT=8'hFF (all digits blank).
  - Round-robin pointer LAST=1, so requester 0 wins the first tie.
  - FSM in IDLE.
- Prescaler:
  - PCNT counts 0..CE_DIV-1 and wraps.
  - DISP_CE = (PCNT==CE_DIV-1), decoded from registered PCNT, glitch-free.
- Phase:
  - PH mirrors the driver's digit counter: reset 7, decrements mod 8 on each DISP_CE.
  - Boundary event BND = DISP_CE & (PH==0). At that edge the driver moves to digit 7 and a new frame begins.
- FSM states:
  - IDLE: no request latched. Any REQx=1 -> PEND.
  - PEND: on BND, arbitrate and latch, then -> ACK. Without BND, stay in PEND.
  - ACK: one cycle. Drive GNTx=1 for the winner. If any REQ=1 -> PEND, else -> IDLE.
- Arbitration on BND:
  - Sample REQ0/REQ1 in the BND cycle.
  - Single requester wins.
  - Both requesting: winner = ~LAST. LAST updates to the winner.
  - Winner's HEX/DP/OFF are registered into the outputs at the BND edge, the same edge the driver wraps to digit 7. The first digit of the new frame therefore shows new data; no tearing.
  - If REQ drops between PEND entry and BND: no latch, no GNT, FSM -> IDLE.
- Handshake:
  - Requester holds REQx and data stable until it sees GNTx.
  - REQx still high in the cycle after GNTx counts as a new request for the next frame.
  - At most one GNT per frame; the loser stays pending, so its worst-case wait is 2 frames.
- FRAME_SOF: registered copy of BND, high for the 1 cycle after every boundary, whether or not a write occurred.
- Without a write, outputs hold their values indefinitely.
- Reset mid-operation: all state returns to reset values immediately; a pending request is dropped without GNT and must be re-issued.

Optional Feature:
- Macro DISP_BLINK_EN.
- Defined:
  - BLINK_MASK port exists.
  - Frame counter FCNT increments on BND, wraps at BLINK_FRAMES-1, and toggles blink phase BPH on wrap. Reset: FCNT=0, BPH=0.
  - OFF_OUT = OFF_reg | (BLINK_MASK & {8{BPH}}). BPH changes only on BND.
- Undefined:
  - No BLINK_MASK port, FCNT or BPH.
  - OFF_OUT = OFF_reg.

Test Plan:
- Reset then run, CE_DIV=4 -> DISP_CE high every 4th cycle (PCNT=3), FRAME_SOF once per 32 cycles, OFF_OUT=8'hFF until first grant.
- REQ0 with HEX0=32'h1234_ABCD, DP0=8'h01, OFF0=0 mid-frame -> outputs unchanged until BND. At the BND edge HEX_OUT=32'h1234_ABCD, DP_OUT=8'h01, OFF_OUT=0, and GNT0=1 for exactly 1 cycle.
- REQ0 and REQ1 both held from reset -> frame 1 grants 0, frame 2 grants 1, frame 3 grants 0. Never two GNTs in one frame.
- REQ1 pulses for 2 cycles mid-frame, then drops before BND -> no GNT1, outputs unchanged, FSM returns to IDLE.
- RST asserted while in PEND -> GNT never pulses, HEX_OUT=0, OFF_OUT=8'hFF, PH=7.
- DISP_BLINK_EN, BLINK_FRAMES=2, BLINK_MASK=8'h80, OFF0=0 granted -> OFF_OUT toggles between 8'h00 and 8'h80 every 2 frames, changing only on BND edges.

Source files
------------

// File: rtl/disp_frame_ctrl.sv
// Frame controller for the 8-digit multiplexed 7-segment driver: digit strobe, phase tracking,
// two-requester round-robin arbitration and tear-free image update. Optional blink: DISP_BLINK_EN.
module disp_frame_ctrl #(
  parameter int CE_DIV       = 12500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0,
  input  logic [31:0] HEX0,
  input  logic [7:0]  DP0,
  input  logic [7:0]  OFF0,
  input  logic        REQ1,
  input  logic [31:0] HEX1,
  input  logic [7:0]  DP1,
  input  logic [7:0]  OFF1,
`ifdef DISP_BLINK_EN
  input  logic [7:0]  BLINK_MASK,
`endif
  output logic        GNT0,
  output logic        GNT1,
  output logic        DISP_CE,
  output logic [31:0] HEX_OUT,
  output logic [7:0]  DP_OUT,
  output logic [7:0]  OFF_OUT,
  output logic        FRAME_SOF
);

  localparam int PCNT_W = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

  if (CE_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_param
    $error("disp_frame_ctrl: CE_DIV must be >= 2 and BLINK_FRAMES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  logic [PCNT_W-1:0] pcnt;
  logic [2:0]        ph;
  logic              bnd;
  logic              any_req;
  logic              arb_win;
  logic              latch;
  state_t            state;
  state_t            state_nxt;
  logic              win_q;
  logic              last_q;
  logic [31:0]       hex_q;
  logic [7:0]        dp_q;
  logic [7:0]        off_q;
  logic              sof_q;

  // Prescaler: strobe decoded from the registered count, so it never glitches.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      pcnt <= '0;
    else if (pcnt == PCNT_W'(CE_DIV - 1))
      pcnt <= '0;
    else
      pcnt <= pcnt + 1'b1;
  end

  assign DISP_CE = (pcnt == PCNT_W'(CE_DIV - 1));

  // Phase mirrors the driver's digit counter; digit 0 -> 7 wrap is the frame boundary.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      ph <= 3'd7;
    else if (DISP_CE)
      ph <= ph - 3'd1;
  end

  assign bnd = DISP_CE && (ph == 3'd0);

  // Arbitration: a lone requester wins; on a tie the side that did not win last time wins.
  always_comb begin
    any_req = REQ0 | REQ1;
    if (REQ0 && REQ1)
      arb_win = ~last_q;
    else
      arb_win = REQ1;
    latch = (state == PEND) && bnd && any_req;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = PEND;
      PEND: if (bnd) state_nxt = any_req ? ACK : IDLE;
      ACK:  state_nxt = any_req ? PEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    GNT0 = (state == ACK) && !win_q;
    GNT1 = (state == ACK) &&  win_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      win_q  <= 1'b0;
      last_q <= 1'b1;
    end else if (latch) begin
      win_q  <= arb_win;
      last_q <= arb_win;
    end
  end

  // Image registers load on the same edge the driver wraps to digit 7, so no frame mixes data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hex_q <= 32'h0;
      dp_q  <= 8'h00;
      off_q <= 8'hFF;
    end else if (latch) begin
      hex_q <= arb_win ? HEX1 : HEX0;
      dp_q  <= arb_win ? DP1  : DP0;
      off_q <= arb_win ? OFF1 : OFF0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      sof_q <= 1'b0;
    else
      sof_q <= bnd;
  end

  assign HEX_OUT   = hex_q;
  assign DP_OUT    = dp_q;
  assign FRAME_SOF = sof_q;

`ifdef DISP_BLINK_EN
  localparam int FCNT_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

  logic [FCNT_W-1:0] fcnt;
  logic              bph;

  // Blink phase flips every BLINK_FRAMES boundaries, so blanking only changes between frames.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fcnt <= '0;
      bph  <= 1'b0;
    end else if (bnd) begin
      if (fcnt == FCNT_W'(BLINK_FRAMES - 1)) begin
        fcnt <= '0;
        bph  <= ~bph;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign OFF_OUT = off_q | (BLINK_MASK & {8{bph}});
`else
  assign OFF_OUT = off_q;
`endif

endmodule

// File: tb/tb_disp_frame_ctrl.sv
// Directed bench for disp_frame_ctrl with CE_DIV=4 (32-cycle frames) and BLINK_FRAMES=2.
module tb_disp_frame_ctrl;

  logic        clk;
  logic        rst;
  logic        req0;
  logic [31:0] hex0;
  logic [7:0]  dp0;
  logic [7:0]  off0;
  logic        req1;
  logic [31:0] hex1;
  logic [7:0]  dp1;
  logic [7:0]  off1;
  logic        gnt0;
  logic        gnt1;
  logic        disp_ce;
  logic [31:0] hex_out;
  logic [7:0]  dp_out;
  logic [7:0]  off_out;
  logic        frame_sof;
`ifdef DISP_BLINK_EN
  logic [7:0]  blink_mask;
`endif

  int n_tests;
  int n_fail;
  int k;

  disp_frame_ctrl #(.CE_DIV(4), .BLINK_FRAMES(2)) dut (
    .CLK(clk),
    .RST(rst),
    .REQ0(req0),
    .HEX0(hex0),
    .DP0(dp0),
    .OFF0(off0),
    .REQ1(req1),
    .HEX1(hex1),
    .DP1(dp1),
    .OFF1(off1),
`ifdef DISP_BLINK_EN
    .BLINK_MASK(blink_mask),
`endif
    .GNT0(gnt0),
    .GNT1(gnt1),
    .DISP_CE(disp_ce),
    .HEX_OUT(hex_out),
    .DP_OUT(dp_out),
    .OFF_OUT(off_out),
    .FRAME_SOF(frame_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    k       = 0;
    rst  = 1'b1;
    req0 = 1'b0; hex0 = 32'h0; dp0 = 8'h00; off0 = 8'h00;
    req1 = 1'b0; hex1 = 32'h0; dp1 = 8'h00; off1 = 8'h00;
`ifdef DISP_BLINK_EN
    blink_mask = 8'h80;
`endif
    #23;
    chk("rst_hex", hex_out, 32'h0);
    chk("rst_dp", {24'h0, dp_out}, 32'h0);
    chk("rst_off", {24'h0, off_out}, 32'hFF);
    chk("rst_gnt", {30'h0, gnt1, gnt0}, 32'h0);
    chk("rst_ce", {31'h0, disp_ce}, 32'h0);
    chk("rst_sof", {31'h0, frame_sof}, 32'h0);
    chk("rst_ph", {29'h0, dut.ph}, 32'd7);

    // First frame with no requests: strobe every 4th cycle, boundary after edge 32.
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (k < 32) begin
      tick();
      chk("ce_cadence", {31'h0, disp_ce}, {31'h0, (k % 4 == 3)});
      chk("sof_cadence", {31'h0, frame_sof}, {31'h0, (k == 32)});
    end
    chk("off_blank_idle", {24'h0, off_out}, 32'hFF);

    // REQ0 mid-frame: image holds until the boundary edge at 64.
    while (k < 40) tick();
    req0 = 1'b1; hex0 = 32'h1234_ABCD; dp0 = 8'h01; off0 = 8'h00;
    while (k < 63) begin
      tick();
      chk("hold_hex", hex_out, 32'h0);
      chk("hold_gnt0", {31'h0, gnt0}, 32'h0);
    end
    chk("bnd_ce", {31'h0, disp_ce}, 32'h1);
    chk("bnd_ph", {29'h0, dut.ph}, 32'd0);
    tick();
    chk("wr_gnt0", {31'h0, gnt0}, 32'h1);
    chk("wr_gnt1", {31'h0, gnt1}, 32'h0);
    chk("wr_hex", hex_out, 32'h1234_ABCD);
    chk("wr_dp", {24'h0, dp_out}, 32'h01);
    chk("wr_off", {24'h0, off_out}, 32'h00);
    chk("wr_sof", {31'h0, frame_sof}, 32'h1);
    req0 = 1'b0;
    tick();
    chk("gnt0_once", {31'h0, gnt0}, 32'h0);
    chk("sof_once", {31'h0, frame_sof}, 32'h0);

    // REQ1 pulse that drops before the boundary is never granted.
    while (k < 70) tick();
    req1 = 1'b1; hex1 = 32'hDEAD_BEEF; dp1 = 8'hFF; off1 = 8'h0F;
    tick();
    tick();
    req1 = 1'b0;
    while (k < 97) begin
      tick();
      chk("drop_gnt1", {31'h0, gnt1}, 32'h0);
      chk("drop_sof", {31'h0, frame_sof}, {31'h0, (k == 96)});
    end
    chk("drop_hex", hex_out, 32'h1234_ABCD);
    chk("drop_dp", {24'h0, dp_out}, 32'h01);
    chk("drop_off", {24'h0, off_out}, 32'h00);

    // Reset while a request is pending drops it without a grant.
    req0 = 1'b1; hex0 = 32'h55AA_55AA; dp0 = 8'h3C; off0 = 8'h00;
    tick();
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0;
    #1;
    chk("rstp_hex", hex_out, 32'h0);
    chk("rstp_off", {24'h0, off_out}, 32'hFF);
    chk("rstp_gnt", {30'h0, gnt1, gnt0}, 32'h0);
    chk("rstp_ph", {29'h0, dut.ph}, 32'd7);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (k < 40) begin
      tick();
      chk("rstp_nognt", {30'h0, gnt1, gnt0}, 32'h0);
    end
    chk("rstp_hex_after", hex_out, 32'h0);

    // Both requesters held from reset: grants alternate 0, 1, 0 on successive frames.
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b1; hex0 = 32'h1111_1111; dp0 = 8'h11; off0 = 8'h00;
    req1 = 1'b1; hex1 = 32'h2222_2222; dp1 = 8'h22; off1 = 8'h0F;
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (k < 97) begin
      tick();
      chk("rr_gnt0", {31'h0, gnt0}, {31'h0, (k == 32 || k == 96)});
      chk("rr_gnt1", {31'h0, gnt1}, {31'h0, (k == 64)});
      if (k == 32) chk("rr_hex_f1", hex_out, 32'h1111_1111);
      if (k == 64) chk("rr_hex_f2", hex_out, 32'h2222_2222);
      if (k == 96) chk("rr_hex_f3", hex_out, 32'h1111_1111);
    end
    req0 = 1'b0;
    req1 = 1'b0;

`ifdef DISP_BLINK_EN
    // Blink: phase flips on every second boundary (64, 128), only on boundary edges.
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b1; hex0 = 32'hCAFE_0000; dp0 = 8'h00; off0 = 8'h00;
    blink_mask = 8'h80;
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (k < 161) begin
      tick();
      if (k == 32)  chk("blink_f1", {24'h0, off_out}, 32'h00);
      if (k == 63)  chk("blink_pre64", {24'h0, off_out}, 32'h00);
      if (k == 64)  chk("blink_f2", {24'h0, off_out}, 32'h80);
      if (k == 96)  chk("blink_f3", {24'h0, off_out}, 32'h80);
      if (k == 127) chk("blink_pre128", {24'h0, off_out}, 32'h80);
      if (k == 128) chk("blink_f4", {24'h0, off_out}, 32'h00);
      if (k == 160) chk("blink_f5", {24'h0, off_out}, 32'h00);
    end
    req0 = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
